messbauer_channel_accumulator: RTL and testbench

- Sits directly downstream of messbauer_generator and consumes its start/channel pulses.
- Counts detector gamma pulses inside each velocity channel.
- When a channel closes, hands the (index, count) pair to the acquisition/readout stage over a valid/ready stream.
- Configured for channel-after-measurement timing: a channel pulse closes the channel just measured.

---
 rtl/messbauer_pkg.sv | 10 +
 rtl/messbauer_channel_accumulator_if.sv | 12 +
 rtl/messbauer_pulse_edge_detector.sv | 13 +
 rtl/messbauer_channel_accumulator.sv | 74 +++++++
 tb/tb_messbauer_channel_accumulator.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/messbauer_pkg.sv
// messbauer_pkg: shared state encoding, default sizing and channel timing constants for the Mossbauer acquisition chain
package messbauer_pkg;
  typedef enum logic [1:0] {IDLE, ACCUMULATE, WAIT_START} state_t;
  typedef enum logic {CHANNEL_AFTER_MEASUREMENT, CHANNEL_BEFORE_MEASUREMENT} channel_type_t;
  localparam int DEF_CHANNELS_NUMBER = 4096;
  localparam int DEF_INDEX_WIDTH = 12;
  localparam int DEF_COUNTER_WIDTH = 16;
  localparam int SWEEP_WIDTH = 16;
  localparam channel_type_t CHANNEL_TYPE = CHANNEL_AFTER_MEASUREMENT;
endpackage

// File: rtl/messbauer_channel_accumulator_if.sv
// messbauer_channel_accumulator_if: valid/ready stream carrying closed-channel (index, count) records
interface messbauer_channel_accumulator_if #(
  parameter int INDEX_WIDTH = 12,
  parameter int COUNTER_WIDTH = 16
);
  logic out_valid;
  logic out_ready;
  logic [INDEX_WIDTH-1:0] out_index;
  logic [COUNTER_WIDTH-1:0] out_count;
  modport master (output out_valid, out_index, out_count, input out_ready);
  modport slave (input out_valid, out_index, out_count, output out_ready);
endinterface

// File: rtl/messbauer_pulse_edge_detector.sv
// messbauer_pulse_edge_detector: one-cycle rising-edge event so a pulse of any length counts once
module messbauer_pulse_edge_detector (
  input  logic aclk,
  input  logic areset_n,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) prev <= 1'b0;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/messbauer_channel_accumulator.sv
// messbauer_channel_accumulator: counts gamma events per velocity channel and streams (index, count) on channel close.
// Define MESSBAUER_GAMMA_SYNC_EN to pass gamma through a 2-flop synchronizer for asynchronous detectors.
module messbauer_channel_accumulator
  import messbauer_pkg::*;
#(
  parameter int CHANNELS_NUMBER = DEF_CHANNELS_NUMBER,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic start,
  input  logic channel,
  input  logic gamma,
  messbauer_channel_accumulator_if.master rec,
  output logic overrun,
  output logic extra_channel,
  output logic [SWEEP_WIDTH-1:0] sweep_number
);
  state_t state, state_d;
  logic [INDEX_WIDTH-1:0] index;
  logic [COUNTER_WIDTH-1:0] counter, counter_inc;
  logic gamma_s, start_ev, channel_ev, gamma_ev, close, last;
`ifdef MESSBAUER_GAMMA_SYNC_EN
  logic [1:0] gamma_sync;
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) gamma_sync <= 2'b00;
    else gamma_sync <= {gamma_sync[0], gamma};
  assign gamma_s = gamma_sync[1];
`else
  assign gamma_s = gamma;
`endif
  messbauer_pulse_edge_detector u_start (.aclk(aclk), .areset_n(areset_n), .d(start), .rise(start_ev));
  messbauer_pulse_edge_detector u_channel (.aclk(aclk), .areset_n(areset_n), .d(channel), .rise(channel_ev));
  messbauer_pulse_edge_detector u_gamma (.aclk(aclk), .areset_n(areset_n), .d(gamma_s), .rise(gamma_ev));
  assign counter_inc = &counter ? counter : counter + 1'b1;
  assign close = (state == ACCUMULATE) && channel_ev;
  assign last = index == INDEX_WIDTH'(CHANNELS_NUMBER - 1);
  // close is evaluated before restart, so start+channel in one cycle still emits the record
  always_comb begin
    state_d = state;
    if (start_ev) state_d = ACCUMULATE;
    else if (close && last) state_d = WAIT_START;
  end
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      index <= '0;
      counter <= '0;
      sweep_number <= '0;
      extra_channel <= 1'b0;
    end else begin
      counter <= (start_ev || close) ? '0 : (state == ACCUMULATE && gamma_ev) ? counter_inc : counter;
      index <= start_ev ? '0 : (close && !last) ? index + 1'b1 : index;
      if (close && last) sweep_number <= sweep_number + 1'b1;
      if (state == WAIT_START && channel_ev) extra_channel <= 1'b1;
    end
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      rec.out_valid <= 1'b0;
      rec.out_index <= '0;
      rec.out_count <= '0;
      overrun <= 1'b0;
    end else if (close && (!rec.out_valid || rec.out_ready)) begin
      rec.out_valid <= 1'b1;
      rec.out_index <= index;
      rec.out_count <= gamma_ev ? counter_inc : counter;
    end else begin
      if (close) overrun <= 1'b1;
      if (rec.out_valid && rec.out_ready) rec.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_messbauer_channel_accumulator.sv
// tb_messbauer_channel_accumulator: directed checks with 8 channels, 3-bit index and 4-bit saturating counter
module tb_messbauer_channel_accumulator;
  import messbauer_pkg::*;
  logic aclk = 1'b0, areset_n = 1'b0, start = 1'b0, channel = 1'b0, gamma = 1'b0;
  logic overrun, extra_channel;
  logic [SWEEP_WIDTH-1:0] sweep_number;
  int passed = 0, total = 0;
  messbauer_channel_accumulator_if #(.INDEX_WIDTH(3), .COUNTER_WIDTH(4)) rec ();
  messbauer_channel_accumulator #(.CHANNELS_NUMBER(8), .INDEX_WIDTH(3), .COUNTER_WIDTH(4)) dut (
    .aclk(aclk), .areset_n(areset_n), .start(start), .channel(channel), .gamma(gamma),
    .rec(rec.master), .overrun(overrun), .extra_channel(extra_channel), .sweep_number(sweep_number)
  );
  always #5 aclk = ~aclk;

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic gam(input int n);
    repeat (n) begin
      gamma = 1'b1; cyc();
      gamma = 1'b0; cyc();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc();
    start = 1'b0; cyc();
  endtask

  task automatic chan();
    channel = 1'b1; cyc();
    channel = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset();
    areset_n = 1'b0; start = 1'b0; channel = 1'b0; gamma = 1'b0; rec.out_ready = 1'b1;
    #1;
    chk("reset_valid", 32'(rec.out_valid), 0);
    chk("reset_index", 32'(rec.out_index), 0);
    chk("reset_count", 32'(rec.out_count), 0);
    chk("reset_flags", {30'd0, overrun, extra_channel}, 0);
    chk("reset_sweep", 32'(sweep_number), 0);
    cyc();
    areset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    pulse_start();
    gam(3);
    chan();
    chk("basic_valid", 32'(rec.out_valid), 1);
    chk("basic_index", 32'(rec.out_index), 0);
    chk("basic_count", 32'(rec.out_count), 3);
    cyc();
    chk("basic_drop", 32'(rec.out_valid), 0);
  endtask

  task automatic test_sweep();
    int g [8] = '{0, 1, 2, 5, 0, 3, 1, 0};
    test_reset();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      gam(g[i]);
      chan();
      chk($sformatf("sweep_idx%0d", i), 32'(rec.out_index), 32'(i));
      chk($sformatf("sweep_cnt%0d", i), 32'(rec.out_count), 32'(g[i]));
      cyc();
    end
    chk("sweep_number", 32'(sweep_number), 1);
    chk("sweep_no_extra", 32'(extra_channel), 0);
    gam(2);
    chan();
    chk("extra_no_record", 32'(rec.out_valid), 0);
    cyc();
    chk("extra_channel", 32'(extra_channel), 1);
    chk("extra_sweep", 32'(sweep_number), 1);
  endtask

  task automatic test_overrun();
    test_reset();
    rec.out_ready = 1'b0;
    pulse_start();
    gam(1);
    chan();
    chk("ovr_first_count", 32'(rec.out_count), 1);
    cyc();
    gam(2);
    chan();
    chk("ovr_hold_valid", 32'(rec.out_valid), 1);
    chk("ovr_hold_index", 32'(rec.out_index), 0);
    chk("ovr_hold_count", 32'(rec.out_count), 1);
    cyc();
    chk("ovr_flag", 32'(overrun), 1);
    rec.out_ready = 1'b1;
    cyc();
    chk("ovr_accepted", 32'(rec.out_valid), 0);
    cyc(); cyc();
    chk("ovr_second_lost", 32'(rec.out_valid), 0);
  endtask

  task automatic test_saturate();
    test_reset();
    pulse_start();
    gam(20);
    chan();
    chk("sat_count", 32'(rec.out_count), 15);
    cyc();
  endtask

  task automatic test_back_to_back();
    test_reset();
    pulse_start();
    gam(2);
    gamma = 1'b1;
    chan();
    gamma = 1'b0;
    chk("same_cycle_count", 32'(rec.out_count), 3);
    chk("same_cycle_index", 32'(rec.out_index), 0);
    cyc();
    chan();
    chk("next_chan_index", 32'(rec.out_index), 1);
    chk("next_chan_count", 32'(rec.out_count), 0);
    cyc();
    gam(1);
    pulse_start();
    chk("restart_no_record", 32'(rec.out_valid), 0);
    gam(2);
    chan();
    chk("restart_index", 32'(rec.out_index), 0);
    chk("restart_count", 32'(rec.out_count), 2);
    cyc();
    gam(1);
    start = 1'b1;
    chan();
    start = 1'b0;
    chk("start_chan_record", 32'(rec.out_index), 1);
    chk("start_chan_count", 32'(rec.out_count), 1);
    cyc();
    chan();
    chk("start_chan_restart", 32'(rec.out_index), 0);
    cyc();
  endtask

  task automatic test_async_reset();
    test_reset();
    rec.out_ready = 1'b0;
    pulse_start();
    repeat (7) begin
      chan();
      cyc();
    end
    gam(1);
    chk("pre_reset_valid", 32'(rec.out_valid), 1);
    #2;
    areset_n = 1'b0;
    #1;
    chk("async_valid", 32'(rec.out_valid), 0);
    chk("async_data", {rec.out_index, rec.out_count}, 0);
    chk("async_flags", {30'd0, overrun, extra_channel}, 0);
    cyc();
    areset_n = 1'b1;
    rec.out_ready = 1'b1;
    cyc();
    chan();
    chk("idle_chan_ignored", 32'(rec.out_valid), 0);
    cyc();
    pulse_start();
    gam(1);
    chan();
    chk("after_reset_index", 32'(rec.out_index), 0);
    chk("after_reset_count", 32'(rec.out_count), 1);
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_overrun();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
